axi_cpld_tlp_builder: RTL and testbench

- Downstream neighbour of the AXI read master in the PCIe-to-AXI-Lite bridge.
- Queues per-read request metadata from the RX request decoder.
- Pairs each entry in order with returning AXI read data (axi_cpld_*), and emits a 3DW CplD TLP (length 1 DW) on a 64-bit AXI-Stream TX interface toward the PCIe core.

---
 rtl/axi_cpld_tlp_builder.sv | 283 ++++++++++++++++++++++++++++
 tb/tb_axi_cpld_tlp_builder.sv | 327 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_cpld_tlp_builder.sv
// ----------------------------------------------------------------------------
// axi_cpld_tlp_builder
//
// Purpose:
//   Turns AXI-Lite read returns into PCIe Completion-with-Data TLPs. Read
//   request metadata from the RX request decoder is queued in a small FIFO.
//   Each returning read data word is paired, in order, with the FIFO head.
//   The result is a 3DW CplD TLP with a length of 1 DW, sent as two beats on
//   a 64-bit AXI-Stream TX interface.
//
// Ports:
//   m_axi_aclk, m_axi_aresetn  clock and asynchronous active-low reset.
//   completer_id               bus/dev/func of this endpoint (quasi-static).
//   req_*                      read metadata push interface (valid/ready).
//   axi_cpld_*                 read data returning from the AXI read master.
//   s_axis_tx_*                64-bit TLP stream toward the PCIe core.
//   cpl_fifo_overflow          sticky flag: metadata arrived while FIFO full.
//
// Notes:
//   m_axi_aresetn is asserted asynchronously. The system reset block is
//   expected to release it synchronously to m_axi_aclk, so no local
//   synchronizer is used. TCQ is kept for parameter compatibility with the
//   rest of the bridge. The registers themselves are modelled without delay.
// ----------------------------------------------------------------------------
module axi_cpld_tlp_builder #(
    parameter int TCQ               = 1,
    parameter int OUTSTANDING_READS = 4
) (
    input  logic        m_axi_aclk,
    input  logic        m_axi_aresetn,
    input  logic [15:0] completer_id,

    input  logic        req_valid,
    output logic        req_ready,
    input  logic [15:0] req_requester_id,
    input  logic [7:0]  req_tag,
    input  logic [2:0]  req_tc,
    input  logic [1:0]  req_attr,
    input  logic [6:0]  req_lower_addr,
    input  logic [3:0]  req_byte_enable,

    input  logic        axi_cpld_valid,
    output logic        axi_cpld_ready,
    input  logic [63:0] axi_cpld_data,

    output logic [63:0] s_axis_tx_tdata,
    output logic [7:0]  s_axis_tx_tkeep,
    output logic        s_axis_tx_tlast,
    output logic        s_axis_tx_tvalid,
    input  logic        s_axis_tx_tready,

    output logic        cpl_fifo_overflow
);

    if (OUTSTANDING_READS < 1 || OUTSTANDING_READS > 16 || TCQ < 0) begin : g_param_check
        $error("axi_cpld_tlp_builder: OUTSTANDING_READS must be 1..16 and TCQ non-negative");
    end

    localparam int PTR_W = (OUTSTANDING_READS > 1) ? $clog2(OUTSTANDING_READS) : 1;
    localparam int CNT_W = $clog2(OUTSTANDING_READS + 1);

    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(OUTSTANDING_READS - 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(OUTSTANDING_READS);

    // state | meaning
    // IDLE  | waiting for read data while the metadata FIFO is non-empty
    // HDR   | beat 0 {DW1,DW0} presented, waiting for tready
    // DATA  | beat 1 {data,DW2} presented with tlast, waiting for tready
    localparam logic [1:0] ST_IDLE = 2'b00;
    localparam logic [1:0] ST_HDR  = 2'b01;
    localparam logic [1:0] ST_DATA = 2'b10;

    typedef struct packed {
        logic [15:0] requester_id;
        logic [7:0]  tag;
        logic [2:0]  tc;
        logic [1:0]  attr;
        logic [6:0]  lower_addr;
        logic [3:0]  byte_enable;
    } meta_t;

    // ------------------------------------------------------------------
    // Metadata FIFO
    // ------------------------------------------------------------------
    meta_t            meta_mem_q [OUTSTANDING_READS];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q,  count_d;
    logic             overflow_q, overflow_d;

    meta_t req_meta;
    meta_t head;
    logic  fifo_empty;
    logic  push;
    logic  pop;

    assign req_meta = '{
        requester_id: req_requester_id,
        tag:          req_tag,
        tc:           req_tc,
        attr:         req_attr,
        lower_addr:   req_lower_addr,
        byte_enable:  req_byte_enable
    };

    assign req_ready  = (count_q != CNT_FULL);
    assign fifo_empty = (count_q == '0);
    assign push       = req_valid & req_ready;
    assign head       = meta_mem_q[rd_ptr_q];

    // Pointers wrap explicitly so that depths that are not powers of two work.
    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q | (req_valid & ~req_ready);

        if (push) begin
            wr_ptr_d = (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + PTR_W'(1);
        end

        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge m_axi_aclk) begin
        if (push) begin
            meta_mem_q[wr_ptr_q] <= req_meta;
        end
    end

    always_ff @(posedge m_axi_aclk or negedge m_axi_aresetn) begin
        if (!m_axi_aresetn) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    assign cpl_fifo_overflow = overflow_q;

    // ------------------------------------------------------------------
    // Completion header fields derived from the FIFO head
    // ------------------------------------------------------------------
    logic [11:0] byte_count;
    logic [1:0]  lo2;
    logic [6:0]  cpl_lower_addr;
    logic [31:0] hdr_dw0;
    logic [31:0] hdr_dw1;
    logic [31:0] hdr_dw2;
    logic [31:0] data_dw;

    // Byte count for a single-DW read is the span from the lowest to the
    // highest enabled byte. An all-zero BE still reports one byte.
    always_comb begin
        byte_count = 12'd1;
        casez (head.byte_enable)
            4'b1??1:                   byte_count = 12'd4;
            4'b01?1, 4'b1?10:          byte_count = 12'd3;
            4'b0011, 4'b0110, 4'b1100: byte_count = 12'd2;
            default:                   byte_count = 12'd1;
        endcase
    end

    always_comb begin
        lo2 = 2'b00;
        casez (head.byte_enable)
            4'b???1: lo2 = 2'b00;
            4'b??10: lo2 = 2'b01;
            4'b?100: lo2 = 2'b10;
            4'b1000: lo2 = 2'b11;
            default: lo2 = 2'b00;
        endcase
    end

    assign cpl_lower_addr = {head.lower_addr[6:2], lo2};

    // fmt=010 (3DW with data), type=01010 (Cpl), TD=EP=0, AT=0, length=1
    assign hdr_dw0 = {3'b010, 5'b01010, 1'b0, head.tc, 4'b0000,
                      1'b0, 1'b0, head.attr, 2'b00, 10'd1};
    assign hdr_dw1 = {completer_id, 3'b000, 1'b0, byte_count};
    assign hdr_dw2 = {head.requester_id, head.tag, 1'b0, cpl_lower_addr};

    // The 64-bit AXI read returns a whole QWORD; address bit 2 picks the DW.
    assign data_dw = head.lower_addr[2] ? axi_cpld_data[63:32] : axi_cpld_data[31:0];

    // ------------------------------------------------------------------
    // TX sequencing
    // ------------------------------------------------------------------
    logic [1:0]  state_q, state_d;
    logic [63:0] tdata_q, tdata_d;
    logic [7:0]  tkeep_q, tkeep_d;
    logic        tlast_q, tlast_d;
    logic        tvalid_q, tvalid_d;
    logic [63:0] beat1_q, beat1_d;

    assign axi_cpld_ready = (state_q == ST_IDLE) & ~fifo_empty;
    assign pop            = axi_cpld_valid & axi_cpld_ready;

    always_comb begin
        state_d  = state_q;
        tdata_d  = tdata_q;
        tkeep_d  = tkeep_q;
        tlast_d  = tlast_q;
        tvalid_d = tvalid_q;
        beat1_d  = beat1_q;

        case (state_q)
            ST_IDLE: begin
                if (pop) begin
                    tdata_d  = {hdr_dw1, hdr_dw0};
                    tkeep_d  = 8'hFF;
                    tlast_d  = 1'b0;
                    tvalid_d = 1'b1;
                    // The FIFO head moves on at this edge, so the second beat
                    // is built now and held until the header is taken.
                    beat1_d  = {data_dw, hdr_dw2};
                    state_d  = ST_HDR;
                end
            end
            ST_HDR: begin
                if (s_axis_tx_tready) begin
                    tdata_d = beat1_q;
                    tkeep_d = 8'hFF;
                    tlast_d = 1'b1;
                    state_d = ST_DATA;
                end
            end
            ST_DATA: begin
                if (s_axis_tx_tready) begin
                    tdata_d  = '0;
                    tkeep_d  = '0;
                    tlast_d  = 1'b0;
                    tvalid_d = 1'b0;
                    state_d  = ST_IDLE;
                end
            end
            default: begin
                tdata_d  = '0;
                tkeep_d  = '0;
                tlast_d  = 1'b0;
                tvalid_d = 1'b0;
                state_d  = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge m_axi_aclk or negedge m_axi_aresetn) begin
        if (!m_axi_aresetn) begin
            state_q  <= ST_IDLE;
            tdata_q  <= '0;
            tkeep_q  <= '0;
            tlast_q  <= 1'b0;
            tvalid_q <= 1'b0;
            beat1_q  <= '0;
        end else begin
            state_q  <= state_d;
            tdata_q  <= tdata_d;
            tkeep_q  <= tkeep_d;
            tlast_q  <= tlast_d;
            tvalid_q <= tvalid_d;
            beat1_q  <= beat1_d;
        end
    end

    assign s_axis_tx_tdata  = tdata_q;
    assign s_axis_tx_tkeep  = tkeep_q;
    assign s_axis_tx_tlast  = tlast_q;
    assign s_axis_tx_tvalid = tvalid_q;

endmodule

// File: tb/tb_axi_cpld_tlp_builder.sv
// ----------------------------------------------------------------------------
// tb_axi_cpld_tlp_builder
//
// Bench for axi_cpld_tlp_builder. A request model mirrors the metadata FIFO.
// When read data is accepted, the two expected TX beats are pushed to a
// scoreboard. They are popped and compared on each TX handshake.
// ----------------------------------------------------------------------------
module tb_axi_cpld_tlp_builder;

    localparam int DEPTH = 4;

    logic        m_axi_aclk = 1'b0;
    logic        m_axi_aresetn;
    logic [15:0] completer_id;
    logic        req_valid;
    logic        req_ready;
    logic [15:0] req_requester_id;
    logic [7:0]  req_tag;
    logic [2:0]  req_tc;
    logic [1:0]  req_attr;
    logic [6:0]  req_lower_addr;
    logic [3:0]  req_byte_enable;
    logic        axi_cpld_valid;
    logic        axi_cpld_ready;
    logic [63:0] axi_cpld_data;
    logic [63:0] s_axis_tx_tdata;
    logic [7:0]  s_axis_tx_tkeep;
    logic        s_axis_tx_tlast;
    logic        s_axis_tx_tvalid;
    logic        s_axis_tx_tready;
    logic        cpl_fifo_overflow;

    axi_cpld_tlp_builder #(.TCQ(1), .OUTSTANDING_READS(DEPTH)) dut (
        .m_axi_aclk        (m_axi_aclk),
        .m_axi_aresetn     (m_axi_aresetn),
        .completer_id      (completer_id),
        .req_valid         (req_valid),
        .req_ready         (req_ready),
        .req_requester_id  (req_requester_id),
        .req_tag           (req_tag),
        .req_tc            (req_tc),
        .req_attr          (req_attr),
        .req_lower_addr    (req_lower_addr),
        .req_byte_enable   (req_byte_enable),
        .axi_cpld_valid    (axi_cpld_valid),
        .axi_cpld_ready    (axi_cpld_ready),
        .axi_cpld_data     (axi_cpld_data),
        .s_axis_tx_tdata   (s_axis_tx_tdata),
        .s_axis_tx_tkeep   (s_axis_tx_tkeep),
        .s_axis_tx_tlast   (s_axis_tx_tlast),
        .s_axis_tx_tvalid  (s_axis_tx_tvalid),
        .s_axis_tx_tready  (s_axis_tx_tready),
        .cpl_fifo_overflow (cpl_fifo_overflow)
    );

    always #5 m_axi_aclk = ~m_axi_aclk;

    typedef struct {
        logic [15:0] rid;
        logic [7:0]  tag;
        logic [2:0]  tc;
        logic [1:0]  attr;
        logic [6:0]  la;
        logic [3:0]  be;
    } req_t;

    typedef struct {
        logic [63:0] data;
        logic        last;
    } beat_t;

    req_t  mq[$];
    beat_t exp_q[$];

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Byte count as the span between the lowest and highest enabled byte.
    function automatic logic [11:0] model_bc(input logic [3:0] be);
        int lo = -1;
        int hi = -1;
        for (int i = 0; i < 4; i++) begin
            if (be[i]) begin
                if (lo < 0) lo = i;
                hi = i;
            end
        end
        return (lo < 0) ? 12'd1 : 12'(hi - lo + 1);
    endfunction

    function automatic logic [1:0] model_lo2(input logic [3:0] be);
        for (int i = 0; i < 4; i++) begin
            if (be[i]) return 2'(i);
        end
        return 2'b00;
    endfunction

    task automatic model_accept(input logic [63:0] d);
        req_t        r;
        beat_t       b0;
        beat_t       b1;
        logic [31:0] dw0;
        logic [31:0] dw1;
        logic [31:0] dw2;
        logic [31:0] ddw;
        if (mq.size() == 0) begin
            chk("accept_with_empty_model", 1, 0);
            return;
        end
        r   = mq.pop_front();
        dw0 = {3'b010, 5'b01010, 1'b0, r.tc, 4'b0, 1'b0, 1'b0, r.attr, 2'b0, 10'd1};
        dw1 = {completer_id, 4'b0000, model_bc(r.be)};
        dw2 = {r.rid, r.tag, 1'b0, r.la[6:2], model_lo2(r.be)};
        ddw = r.la[2] ? d[63:32] : d[31:0];
        b0.data = {dw1, dw0};
        b0.last = 1'b0;
        b1.data = {ddw, dw2};
        b1.last = 1'b1;
        exp_q.push_back(b0);
        exp_q.push_back(b1);
    endtask

    // All drive tasks start and end 1 time unit after a rising edge.
    task automatic push_req(input logic [15:0] rid, input logic [7:0] tag, input logic [2:0] tc,
                            input logic [1:0] attr, input logic [6:0] la, input logic [3:0] be);
        req_t r;
        logic exp_rdy;
        r.rid = rid; r.tag = tag; r.tc = tc; r.attr = attr; r.la = la; r.be = be;
        exp_rdy = (mq.size() < DEPTH);
        req_valid        = 1'b1;
        req_requester_id = rid;
        req_tag          = tag;
        req_tc           = tc;
        req_attr         = attr;
        req_lower_addr   = la;
        req_byte_enable  = be;
        chk("req_ready", req_ready, exp_rdy);
        if (exp_rdy) mq.push_back(r);
        @(posedge m_axi_aclk); #1;
        req_valid = 1'b0;
    endtask

    task automatic send_data(input logic [63:0] d);
        bit done = 0;
        axi_cpld_valid = 1'b1;
        axi_cpld_data  = d;
        for (int i = 0; i < 100 && !done; i++) begin
            if (axi_cpld_ready) begin
                model_accept(d);
                done = 1;
            end
            @(posedge m_axi_aclk); #1;
        end
        axi_cpld_valid = 1'b0;
        if (!done) chk("data_accept_timeout", 0, 1);
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 200 && exp_q.size() != 0; i++) begin
            @(posedge m_axi_aclk); #1;
        end
        if (exp_q.size() != 0) chk("drain_timeout", 64'(exp_q.size()), 0);
    endtask

    // TX monitor, sampling on the falling edge
    always @(negedge m_axi_aclk) begin
        if (m_axi_aresetn) begin
            if (s_axis_tx_tvalid) chk("ready_while_busy", axi_cpld_ready, 0);
            if (s_axis_tx_tvalid && s_axis_tx_tready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_beat", 1, 0);
                end else begin
                    beat_t b;
                    b = exp_q.pop_front();
                    chk("tdata", s_axis_tx_tdata, b.data);
                    chk("tlast", s_axis_tx_tlast, b.last);
                    chk("tkeep", s_axis_tx_tkeep, 8'hFF);
                end
            end else if (s_axis_tx_tvalid && exp_q.size() != 0) begin
                chk("held_tdata", s_axis_tx_tdata, exp_q[0].data);
                chk("held_tlast", s_axis_tx_tlast, exp_q[0].last);
            end
        end
    end

    initial begin
        m_axi_aresetn    = 1'b0;
        completer_id     = 16'h0100;
        req_valid        = 1'b0;
        req_requester_id = '0;
        req_tag          = '0;
        req_tc           = '0;
        req_attr         = '0;
        req_lower_addr   = '0;
        req_byte_enable  = '0;
        axi_cpld_valid   = 1'b0;
        axi_cpld_data    = '0;
        s_axis_tx_tready = 1'b1;

        repeat (3) @(posedge m_axi_aclk);
        #1;
        chk("rst_tvalid", s_axis_tx_tvalid, 0);
        chk("rst_tlast", s_axis_tx_tlast, 0);
        chk("rst_tdata", s_axis_tx_tdata, 0);
        chk("rst_tkeep", s_axis_tx_tkeep, 0);
        chk("rst_cpld_ready", axi_cpld_ready, 0);
        chk("rst_overflow", cpl_fifo_overflow, 0);
        chk("rst_req_ready", req_ready, 1);
        m_axi_aresetn = 1'b1;
        @(posedge m_axi_aclk); #1;

        // Basic completion from the reference example
        push_req(16'h0008, 8'h12, 3'd0, 2'd0, 7'h04, 4'b1111);
        send_data(64'hDEADBEEF_CAFEF00D);
        wait_drain();

        // Byte-enable corner cases, then mixed TC/attr
        push_req(16'h0010, 8'h20, 3'd0, 2'd0, 7'h10, 4'b0110);
        send_data(64'h11112222_33334444);
        push_req(16'h0011, 8'h21, 3'd1, 2'd1, 7'h08, 4'b1000);
        send_data(64'h55556666_77778888);
        push_req(16'h0012, 8'h22, 3'd7, 2'd3, 7'h7C, 4'b0000);
        send_data(64'h9999AAAA_BBBBCCCC);
        for (int i = 0; i < 6; i++) begin
            push_req(16'($urandom), 8'($urandom), 3'($urandom), 2'($urandom),
                     7'($urandom), 4'($urandom));
            send_data({$urandom, $urandom});
        end
        wait_drain();

        // Fill the FIFO, overflow it, then drain in order
        for (int t = 1; t <= 4; t++) begin
            push_req(16'h0100, 8'(t), 3'd0, 2'd0, 7'(4 * t), 4'b1111);
        end
        push_req(16'h0100, 8'd5, 3'd0, 2'd0, 7'h00, 4'b1111);
        chk("overflow_set", cpl_fifo_overflow, 1);
        for (int t = 1; t <= 4; t++) begin
            send_data({32'(t) << 8, 32'(t)});
        end
        wait_drain();
        chk("overflow_sticky", cpl_fifo_overflow, 1);

        // Back-pressure in HDR and in DATA, with a second completion waiting
        push_req(16'h0200, 8'h31, 3'd2, 2'd2, 7'h00, 4'b0011);
        push_req(16'h0201, 8'h32, 3'd0, 2'd0, 7'h44, 4'b1100);
        s_axis_tx_tready = 1'b0;
        send_data(64'hA1A1A1A1_B2B2B2B2);
        axi_cpld_valid = 1'b1;
        axi_cpld_data  = 64'hC3C3C3C3_D4D4D4D4;
        repeat (5) begin
            @(posedge m_axi_aclk); #1;
        end
        s_axis_tx_tready = 1'b1;
        @(posedge m_axi_aclk); #1;
        s_axis_tx_tready = 1'b0;
        repeat (5) begin
            @(posedge m_axi_aclk); #1;
        end
        chk("stall_data_last", s_axis_tx_tlast, 1);
        s_axis_tx_tready = 1'b1;
        @(posedge m_axi_aclk); #1;
        chk("next_accept", axi_cpld_ready, 1);
        if (axi_cpld_ready) model_accept(axi_cpld_data);
        @(posedge m_axi_aclk); #1;
        axi_cpld_valid = 1'b0;
        wait_drain();

        // Read data with an empty FIFO must be ignored
        axi_cpld_valid = 1'b1;
        axi_cpld_data  = 64'h0BADF00D_0BADF00D;
        repeat (10) begin
            chk("empty_no_ready", axi_cpld_ready, 0);
            @(posedge m_axi_aclk); #1;
        end
        chk("empty_no_tlp", s_axis_tx_tvalid, 0);
        push_req(16'h0300, 8'h40, 3'd0, 2'd0, 7'h04, 4'b0001);
        chk("accept_after_push", axi_cpld_ready, 1);
        if (axi_cpld_ready) model_accept(axi_cpld_data);
        @(posedge m_axi_aclk); #1;
        axi_cpld_valid = 1'b0;
        wait_drain();

        // Reset while the data beat is presented
        s_axis_tx_tready = 1'b0;
        push_req(16'h0400, 8'h50, 3'd0, 2'd0, 7'h00, 4'b1111);
        push_req(16'h0401, 8'h51, 3'd0, 2'd0, 7'h00, 4'b1111);
        send_data(64'h12345678_9ABCDEF0);
        s_axis_tx_tready = 1'b1;
        @(posedge m_axi_aclk); #1;
        s_axis_tx_tready = 1'b0;
        chk("pre_rst_tlast", s_axis_tx_tlast, 1);
        #2;
        m_axi_aresetn = 1'b0;
        #1;
        chk("async_rst_tvalid", s_axis_tx_tvalid, 0);
        exp_q.delete();
        mq.delete();
        repeat (3) @(posedge m_axi_aclk);
        #1;
        m_axi_aresetn    = 1'b1;
        s_axis_tx_tready = 1'b1;
        @(posedge m_axi_aclk); #1;
        chk("post_rst_req_ready", req_ready, 1);
        chk("post_rst_overflow", cpl_fifo_overflow, 0);
        axi_cpld_valid = 1'b1;
        #1;
        chk("post_rst_fifo_empty", axi_cpld_ready, 0);
        axi_cpld_valid = 1'b0;
        @(posedge m_axi_aclk); #1;

        push_req(16'h0500, 8'h60, 3'd3, 2'd1, 7'h24, 4'b0100);
        send_data(64'hFEEDFACE_00C0FFEE);
        wait_drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
